// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP.
// Optional perf counters under `PERF_COUNTER_EN.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 ir_write_en,
  output logic                 pc_write_en,
  output logic                 pc_src_sel,
  output logic                 dmem_read_en,
  output logic                 dmem_write_en,
  output logic                 reg_write_en,
  output logic                 trap,
`ifdef PERF_COUNTER_EN
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_retired,
`endif
  output logic [2:0]           state
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd7
  } state_t;

  state_t        cur;
  logic [TW-1:0] wait_cnt;
  logic          lw_q;
  logic          sw_q;
  logic          br_q;

  logic is_lw;
  logic is_sw;
  logic is_br;
  logic legal;
  logic timeout;
  logic retire;

  always_comb begin
    is_lw = 1'b0;
    is_sw = 1'b0;
    is_br = 1'b0;
    legal = 1'b1;
    unique case (1'b1)
      (opcode == 7'b0110011): ;
      (opcode == 7'b0010011): ;
      (opcode == 7'b0000011): is_lw = 1'b1;
      (opcode == 7'b0100011): is_sw = 1'b1;
      (opcode == 7'b1100011): is_br = 1'b1;
      default:                legal = 1'b0;
    endcase
  end

  assign timeout = (wait_cnt == TW'(MEM_TIMEOUT - 1));

  // Wait counter clears on every transition; only waiting states hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
      lw_q     <= 1'b0;
      sw_q     <= 1'b0;
      br_q     <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (cur)
        S_FETCH: begin
          if (imem_ready)
            cur <= S_DECODE;
          else if (timeout)
            cur <= S_TRAP;
          else
            wait_cnt <= wait_cnt + TW'(1);
        end
        S_DECODE: begin
          lw_q <= is_lw;
          sw_q <= is_sw;
          br_q <= is_br;
          cur  <= legal ? S_EXECUTE : S_TRAP;
        end
        S_EXECUTE: begin
          if (br_q)
            cur <= S_FETCH;
          else if (lw_q || sw_q)
            cur <= S_MEM;
          else
            cur <= S_WB;
        end
        S_MEM: begin
          if (dmem_ack)
            cur <= lw_q ? S_WB : S_FETCH;
          else if (timeout)
            cur <= S_TRAP;
          else
            wait_cnt <= wait_cnt + TW'(1);
        end
        S_WB:    cur <= S_FETCH;
        S_TRAP:  cur <= S_TRAP;
        default: cur <= S_TRAP;
      endcase
    end
  end

  assign retire = (cur == S_EXECUTE && br_q)
               || (cur == S_MEM && sw_q && dmem_ack)
               || (cur == S_WB);

  // Strobes are gated by rst_n so they fall the instant reset asserts.
  assign imem_req      = rst_n && (cur == S_FETCH);
  assign ir_write_en   = imem_req && imem_ready;
  assign dmem_read_en  = rst_n && (cur == S_MEM) && lw_q;
  assign dmem_write_en = rst_n && (cur == S_MEM) && sw_q;
  assign reg_write_en  = rst_n && (cur == S_WB);
  assign pc_write_en   = rst_n && retire;
  assign pc_src_sel    = rst_n && (cur == S_EXECUTE)
                      && br_q && branch_taken;
  assign trap          = rst_n && (cur == S_TRAP);
  assign state         = cur;

`ifdef PERF_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= '0;
      instr_retired <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_WIDTH'(1);
      if (retire)
        instr_retired <= instr_retired + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench for multicycle_sequencer.
// Reference model expands each instruction into its expected cycle trace.
module tb_multicycle_sequencer;

  localparam int T = 16;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req;
  logic       ir_write_en;
  logic       pc_write_en;
  logic       pc_src_sel;
  logic       dmem_read_en;
  logic       dmem_write_en;
  logic       reg_write_en;
  logic       trap;
  logic [2:0] state;
`ifdef PERF_COUNTER_EN
  logic [31:0] cycle_count;
  logic [31:0] instr_retired;
`endif

  multicycle_sequencer #(.MEM_TIMEOUT(T), .CNT_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .imem_ready    (imem_ready),
    .dmem_ack      (dmem_ack),
    .imem_req      (imem_req),
    .ir_write_en   (ir_write_en),
    .pc_write_en   (pc_write_en),
    .pc_src_sel    (pc_src_sel),
    .dmem_read_en  (dmem_read_en),
    .dmem_write_en (dmem_write_en),
    .reg_write_en  (reg_write_en),
    .trap          (trap),
`ifdef PERF_COUNTER_EN
    .cycle_count   (cycle_count),
    .instr_retired (instr_retired),
`endif
    .state         (state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_cyc = 0;
  int exp_ret = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk(
    bit tr, logic [2:0] st, bit ireq, bit irw,
    bit pcw, bit pcs, bit rd, bit wr, bit rw);
    return {tr, st, ireq, irw, pcw, pcs, rd, wr, rw};
  endfunction

  function automatic logic [10:0] obs();
    return {trap, state, imem_req, ir_write_en,
            pc_write_en, pc_src_sel, dmem_read_en,
            dmem_write_en, reg_write_en};
  endfunction

  function automatic bit r();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input string tag, input bit rdy,
                      input bit ack, input bit bt,
                      input logic [10:0] e, input bit ret);
    imem_ready   = rdy;
    dmem_ack     = ack;
    branch_taken = bt;
    @(negedge clk);
    check(tag, 32'(obs()), 32'(e));
`ifdef PERF_COUNTER_EN
    check({tag, "_cyc"}, cycle_count, 32'(exp_cyc));
    check({tag, "_ret"}, instr_retired, 32'(exp_ret));
`endif
    @(posedge clk);
    #1;
    exp_cyc++;
    if (ret) exp_ret++;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    imem_ready   = 1'b0;
    dmem_ack     = 1'b0;
    branch_taken = 1'b0;
    #1;
    check("reset_out", 32'(obs()), 32'd0);
`ifdef PERF_COUNTER_EN
    check("reset_cyc", cycle_count, 32'd0);
    check("reset_ret", instr_retired, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_cyc = 0;
    exp_ret = 0;
  endtask

  task automatic trap_tail(input int n);
    for (int i = 0; i < n; i++)
      step("trap", r(), r(), r(),
           mk(1, 3'd7, 0, 0, 0, 0, 0, 0, 0), 0);
    do_reset();
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw,
                           input int mw, input bit bt);
    bit lw;
    bit sw;
    bit br;
    bit legal;
    bit a;
    int n;
    lw = (op == OP_LW);
    sw = (op == OP_SW);
    br = (op == OP_BR);
    legal = lw || sw || br || op == OP_R || op == OP_I;
    opcode = op;
    n = (fw >= T) ? T : fw + 1;
    for (int i = 0; i < n; i++) begin
      a = (i == fw);
      step("fetch", a, r(), r(),
           mk(0, 3'd0, 1, a, 0, 0, 0, 0, 0), 0);
    end
    if (fw >= T) begin
      trap_tail(4);
      return;
    end
    step("decode", r(), r(), r(),
         mk(0, 3'd1, 0, 0, 0, 0, 0, 0, 0), 0);
    if (!legal) begin
      trap_tail(20);
      return;
    end
    if (br) begin
      step("exec_br", r(), r(), bt,
           mk(0, 3'd2, 0, 0, 1, bt, 0, 0, 0), 1);
      return;
    end
    step("exec", r(), r(), r(),
         mk(0, 3'd2, 0, 0, 0, 0, 0, 0, 0), 0);
    if (lw || sw) begin
      n = (mw >= T) ? T : mw + 1;
      for (int i = 0; i < n; i++) begin
        a = (i == mw);
        step("mem", r(), a, r(),
             mk(0, 3'd3, 0, 0, sw && a, 0, lw, sw, 0),
             sw && a);
      end
      if (mw >= T) begin
        trap_tail(4);
        return;
      end
      if (sw) return;
    end
    step("wb", r(), r(), r(),
         mk(0, 3'd4, 0, 0, 1, 0, 0, 0, 1), 1);
  endtask

  task automatic mid_reset_lw();
    opcode = OP_LW;
    step("mr_fetch", 1, 0, 0,
         mk(0, 3'd0, 1, 1, 0, 0, 0, 0, 0), 0);
    step("mr_dec", 0, 0, 0,
         mk(0, 3'd1, 0, 0, 0, 0, 0, 0, 0), 0);
    step("mr_exec", 0, 0, 0,
         mk(0, 3'd2, 0, 0, 0, 0, 0, 0, 0), 0);
    step("mr_mem", 0, 0, 0,
         mk(0, 3'd3, 0, 0, 0, 0, 1, 0, 0), 0);
    step("mr_mem", 0, 0, 0,
         mk(0, 3'd3, 0, 0, 0, 0, 1, 0, 0), 0);
    #1;
    check("mr_rd_pre", 32'(dmem_read_en), 32'd1);
    do_reset();
    step("mr_after", 0, 0, 0,
         mk(0, 3'd0, 1, 0, 0, 0, 0, 0, 0), 0);
  endtask

  function automatic int pick_wait();
    int k;
    k = $urandom_range(0, 9);
    if (k == 8) return T - 1;
    if (k == 9) return T;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    logic [6:0] ops [6];
    logic [6:0] op;
    ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_R};
    #1;
    do_reset();
    run_instr(OP_R, 0, 0, 0);
    run_instr(OP_LW, 0, 2, 0);
    run_instr(OP_SW, 1, 4, 0);
    run_instr(OP_BR, 0, 0, 1);
    run_instr(OP_BR, 2, 0, 0);
    run_instr(OP_I, 0, 0, 0);
    run_instr(7'b1111111, 0, 0, 0);
    run_instr(OP_R, T, 0, 0);
    run_instr(OP_R, T - 1, 0, 0);
    run_instr(OP_LW, 0, T - 1, 0);
    run_instr(OP_SW, 0, T, 0);
    mid_reset_lw();
    do_reset();
    for (int i = 0; i < 3; i++)
      run_instr(OP_R, 0, 0, 0);
`ifdef PERF_COUNTER_EN
    #1;
    check("retired_3r", instr_retired, 32'd3);
`endif
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 9)
        op = 7'($urandom_range(0, 127));
      else
        op = ops[$urandom_range(0, 5)];
      run_instr(op, pick_wait(), pick_wait(), r());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
